adc_lane_rr_sched: RTL and testbench
====================================

// Module: adc_lane_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one 8-bit output stream among PORTS ADC lanes.
//  Each lane has a 1-entry hold register. Lanes are granted in cyclic order.
//  Per lane, the sample is optionally converted from offset binary to two's complement (MSB flip).
//  Sits after the ADC lane deserialisers and feeds the single-stream sample FIFO/DSP.
// PARAMETERS
//  PORTS   8   number of ADC lanes (2..16)
//  CNT_W   16  width of the saturating drop counter
// PORTS
//  CLK         in   1             system clock, all logic on rising edge
//  RST         in   1             asynchronous reset, active high
//  EN          in   1             capture enable; 0 = ignore IN_VALID, held samples still drain
//  CLR         in   1             sync clear of DROP_CNT and DROP_STICKY
//  FMT_TC      in   PORTS         per lane: 1 = emit two's complement, 0 = pass offset binary
//  IN_DATA     in   [PORTS][8]    per-lane sample, offset binary
//  IN_VALID    in   PORTS         per-lane sample strobe, no backpressure to lanes
//  OUT_DATA    out  8             scheduled sample
//  OUT_LANE    out  $clog2(PORTS) source lane of OUT_DATA
//  OUT_VALID   out  1             OUT_DATA/OUT_LANE valid
//  OUT_READY   in   1             downstream accept; transfer = OUT_VALID & OUT_READY
//  DROP_CNT    out  CNT_W         total dropped samples, saturates at all-ones
//  DROP_STICKY out  PORTS         per-lane "a drop occurred" flag
// BEHAVIOUR
//  Reset (RST=1, async):
//   - All holds empty; OUT_VALID=0; OUT_DATA=0; OUT_LANE=0.
//   - DROP_CNT=0; DROP_STICKY=0; rr pointer=PORTS-1, so lane 0 wins first.
//   - Reset mid-transfer discards all held and output samples without a drop count.
//  Capture:
//   - Lane i loads its hold when EN & IN_VALID[i].
//   - Empty hold: the sample is taken.
//   - Full hold drained by a grant in the same cycle: the new sample is taken (no drop).
//   - Full hold not drained: the new sample is discarded and the old one kept.
//     DROP_STICKY[i] is set. DROP_CNT increments by the number of lanes dropping that cycle, saturating.
//  Output register:
//   - It is "free" when !OUT_VALID | OUT_READY.
//   - When free and any hold is full, grant the first full lane strictly after the pointer (cyclic).
//   - On grant: OUT_DATA = FMT_TC[g] ? {~h[7],h[6:0]} : h; OUT_LANE=g; OUT_VALID=1.
//     The hold is emptied and pointer=g.
//   - FMT_TC is sampled at grant time, not at capture.
//   - Free with no full hold: OUT_VALID=0. OUT_DATA/OUT_LANE hold their last values.
//   - While OUT_VALID & !OUT_READY: OUT_DATA/OUT_LANE stay stable and no grant occurs.
//  Latency: IN_VALID at edge t -> OUT_VALID at edge t+1 minimum (output free, no contention).
//  Throughput: one sample per cycle. All lanes valid every cycle -> each lane is served every PORTS cycles.
//  Counters:
//   - CLR=1 zeroes DROP_CNT and DROP_STICKY.
//   - CLR wins over a drop in the same cycle; that drop is neither counted nor flagged.
//  EN falling: no new captures; full holds keep draining in rr order.
// STRUCTURE
//  Package adc_rx_pkg:
//   - localparam ADC_W=8
//   - typedef logic [ADC_W-1:0] adc_smp_t
//   - function bo2tc(adc_smp_t) returning MSB-flipped value
//  Sub-module rr_arb #(N):
//   - inputs: req[N], ptr, en
//   - outputs: gnt_vld, gnt_idx, combinational
//   - grants the first req strictly after ptr, cyclic
//  Top: hold regs, output reg, pointer, drop logic.
// TESTING
//  1 Reset check (PORTS=8): reset, then lane 3 IN_DATA=8'h80 FMT_TC[3]=1, OUT_READY=1
//    -> next cycle OUT_VALID=1, OUT_DATA=8'h00, OUT_LANE=3.
//  2 Passthrough: same as 1 with FMT_TC[3]=0 -> OUT_DATA=8'h80. Input 8'h7F, FMT_TC=1 -> 8'hFF.
//  3 Fairness: all lanes IN_VALID=1 with IN_DATA=lane index, each for one cycle, OUT_READY=1
//    -> OUT_LANE sequence 0,1,...,7. DROP_CNT=0.
//  4 Backpressure: OUT_READY=0 for 10 cycles while lane 2 strobes every cycle
//    -> OUT_DATA stable; DROP_CNT=9; DROP_STICKY=8'h04.
//    Release -> first sample out, then later ones resume.
//  5 Simultaneous: lane 5 hold full, granted and IN_VALID[5] in the same cycle -> no drop.
//    The new sample appears on the next grant.
//  6 CLR & DROP_CNT together: CLR in the same cycle as a drop -> DROP_CNT=0, DROP_STICKY=0.
//    Saturation: CNT_W=4, force 20 drops -> DROP_CNT=4'hF.
//    Async RST pulse mid-stream -> OUT_VALID drops immediately, lane 0 is granted first afterwards.

Source files
------------

// File: rtl/adc_rx_pkg.sv
// rtl/adc_rx_pkg.sv - shared ADC sample type and format helper
package adc_rx_pkg;

  localparam int ADC_W = 8;

  typedef logic [ADC_W-1:0] adc_smp_t;

  // Offset binary to two's complement is just an MSB flip.
  function automatic adc_smp_t bo2tc(input adc_smp_t s);
    return {~s[ADC_W-1], s[ADC_W-2:0]};
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter, grants first request strictly after ptr
module rr_arb #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  int          cand;
  logic [IW-1:0] ci;

  // Walk ptr+1 .. ptr+N; the lane at ptr itself is considered last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    ci      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      ci   = cand[IW-1:0];
      if (en && !gnt_vld && req[ci]) begin
        gnt_vld = 1'b1;
        gnt_idx = ci;
      end
    end
  end

endmodule

// File: rtl/adc_lane_rr_sched.sv
// rtl/adc_lane_rr_sched.sv - round-robin merge of PORTS ADC lanes into one sample stream
module adc_lane_rr_sched
  import adc_rx_pkg::*;
#(
  parameter int PORTS = 8,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic                       CLR,
  input  logic [PORTS-1:0]           FMT_TC,
  input  adc_smp_t [PORTS-1:0]       IN_DATA,
  input  logic [PORTS-1:0]           IN_VALID,
  output adc_smp_t                   OUT_DATA,
  output logic [$clog2(PORTS)-1:0]   OUT_LANE,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [CNT_W-1:0]           DROP_CNT,
  output logic [PORTS-1:0]           DROP_STICKY
);

  localparam int LW = $clog2(PORTS);

  adc_smp_t          hold_q [PORTS];
  adc_smp_t          hold_d [PORTS];
  logic [PORTS-1:0]  full_q, full_d;
  adc_smp_t          out_data_q, out_data_d;
  logic [LW-1:0]     out_lane_q, out_lane_d;
  logic              out_vld_q, out_vld_d;
  logic [LW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PORTS-1:0]  sticky_q, sticky_d;

  logic              free;
  logic              gnt_vld;
  logic [LW-1:0]     gnt_idx;
  logic [PORTS-1:0]  gnt_oh;
  logic [PORTS-1:0]  cap;
  logic [PORTS-1:0]  drop;
  logic [4:0]        n_drop;
  logic [CNT_W+4:0]  cnt_sum;

  assign free = !out_vld_q || OUT_READY;
  assign cap  = IN_VALID & {PORTS{EN}};

  rr_arb #(
    .N  (PORTS),
    .IW (LW)
  ) u_arb (
    .req     (full_q),
    .ptr     (ptr_q),
    .en      (free),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Hold registers: a grant in the same cycle frees the slot for the new sample.
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    n_drop = '0;
    drop   = '0;
    for (int i = 0; i < PORTS; i++) begin
      hold_d[i] = hold_q[i];
      full_d[i] = full_q[i] & ~gnt_oh[i];
      drop[i]   = cap[i] & full_q[i] & ~gnt_oh[i];
      if (cap[i] && (!full_q[i] || gnt_oh[i])) begin
        hold_d[i] = IN_DATA[i];
        full_d[i] = 1'b1;
      end
      n_drop = n_drop + {4'b0, drop[i]};
    end
  end

  // Format conversion uses FMT_TC as seen at grant time.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    ptr_d      = ptr_q;
    if (free) begin
      out_vld_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = FMT_TC[gnt_idx] ? bo2tc(hold_q[gnt_idx]) : hold_q[gnt_idx];
        out_lane_d = gnt_idx;
        ptr_d      = gnt_idx;
      end
    end
  end

  // CLR takes priority over any drop in the same cycle.
  always_comb begin
    cnt_sum    = {5'b0, drop_cnt_q} + {{CNT_W{1'b0}}, n_drop};
    drop_cnt_d = (|cnt_sum[CNT_W+4:CNT_W]) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    sticky_d   = sticky_q | drop;
    if (CLR) begin
      drop_cnt_d = '0;
      sticky_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PORTS; i++) hold_q[i] <= '0;
      full_q     <= '0;
      out_data_q <= '0;
      out_lane_q <= '0;
      out_vld_q  <= 1'b0;
      ptr_q      <= LW'(PORTS - 1);
      drop_cnt_q <= '0;
      sticky_q   <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) hold_q[i] <= hold_d[i];
      full_q     <= full_d;
      out_data_q <= out_data_d;
      out_lane_q <= out_lane_d;
      out_vld_q  <= out_vld_d;
      ptr_q      <= ptr_d;
      drop_cnt_q <= drop_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign OUT_DATA    = out_data_q;
  assign OUT_LANE    = out_lane_q;
  assign OUT_VALID   = out_vld_q;
  assign DROP_CNT    = drop_cnt_q;
  assign DROP_STICKY = sticky_q;

endmodule

// File: tb/tb_adc_lane_rr_sched.sv
// tb/tb_adc_lane_rr_sched.sv - directed bench for adc_lane_rr_sched
module tb_adc_lane_rr_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clr;
  logic [7:0]       fmt;
  logic [7:0][7:0]  in_data;
  logic [7:0]       in_valid;
  logic             ready;

  logic [7:0]       out_data, sat_out_data;
  logic [2:0]       out_lane, sat_out_lane;
  logic             out_valid, sat_out_valid;
  logic [15:0]      drop_cnt;
  logic [3:0]       sat_drop_cnt;
  logic [7:0]       sticky, sat_sticky;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adc_lane_rr_sched #(.PORTS(8), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .FMT_TC(fmt),
    .IN_DATA(in_data), .IN_VALID(in_valid),
    .OUT_DATA(out_data), .OUT_LANE(out_lane), .OUT_VALID(out_valid),
    .OUT_READY(ready), .DROP_CNT(drop_cnt), .DROP_STICKY(sticky)
  );

  adc_lane_rr_sched #(.PORTS(8), .CNT_W(4)) dut_sat (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .FMT_TC(fmt),
    .IN_DATA(in_data), .IN_VALID(in_valid),
    .OUT_DATA(sat_out_data), .OUT_LANE(sat_out_lane), .OUT_VALID(sat_out_valid),
    .OUT_READY(ready), .DROP_CNT(sat_drop_cnt), .DROP_STICKY(sat_sticky)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; fmt = '0;
    in_data = '0; in_valid = '0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_lane", 32'(out_lane), 32'h0);
    check("rst_cnt", 32'(drop_cnt), 32'h0);
    check("rst_sticky", 32'(sticky), 32'h0);

    // Two's complement conversion of lane 3
    in_data[3] = 8'h80; fmt[3] = 1'b1; in_valid = 8'h08;
    tick;
    check("t1_capture_valid", 32'(out_valid), 32'h0);
    in_valid = '0;
    tick;
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h00);
    check("t1_lane", 32'(out_lane), 32'h3);
    tick;
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    check("t1_idle_data", 32'(out_data), 32'h00);
    check("t1_idle_lane", 32'(out_lane), 32'h3);

    // Passthrough and 7F -> FF
    fmt[3] = 1'b0; in_valid = 8'h08;
    tick; in_valid = '0; tick;
    check("t2_pass", 32'(out_data), 32'h80);
    in_data[3] = 8'h7F; fmt[3] = 1'b1; in_valid = 8'h08;
    tick; in_valid = '0; tick;
    check("t2_tc7f", 32'(out_data), 32'hFF);

    // Pointer back to PORTS-1 so lane 0 leads
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    fmt = '0;

    // Fairness
    for (int i = 0; i < 8; i++) in_data[i] = 8'(i);
    in_valid = 8'hFF;
    tick;
    in_valid = '0;
    for (int k = 0; k < 8; k++) begin
      tick;
      check($sformatf("t3_lane%0d", k), 32'(out_lane), 32'(k));
      check($sformatf("t3_data%0d", k), 32'(out_data), 32'(k));
    end
    check("t3_cnt", 32'(drop_cnt), 32'h0);
    tick;
    check("t3_drained", 32'(out_valid), 32'h0);

    // Backpressure with lane 6 stuck in the output register
    ready = 1'b0;
    in_data[6] = 8'h66; in_valid = 8'h40;
    tick; in_valid = '0; tick;
    check("t4_stuck_valid", 32'(out_valid), 32'h1);
    check("t4_stuck_lane", 32'(out_lane), 32'h6);
    for (int k = 0; k < 10; k++) begin
      in_data[2] = 8'(8'h20 + k); in_valid = 8'h04;
      tick;
      check($sformatf("t4_stable%0d", k), 32'(out_data), 32'h66);
    end
    in_valid = '0;
    check("t4_cnt", 32'(drop_cnt), 32'd9);
    check("t4_sticky", 32'(sticky), 32'h04);
    check("t4_sat_cnt", 32'(sat_drop_cnt), 32'd9);
    ready = 1'b1;
    tick;
    check("t4_rel_data", 32'(out_data), 32'h20);
    check("t4_rel_lane", 32'(out_lane), 32'h2);
    in_data[2] = 8'h55; in_valid = 8'h04;
    tick;
    check("t4_gap_valid", 32'(out_valid), 32'h0);
    in_valid = '0;
    tick;
    check("t4_resume", 32'(out_data), 32'h55);

    // Grant and capture on lane 5 in the same cycle
    in_data[5] = 8'h51; in_valid = 8'h20;
    tick;
    in_data[5] = 8'h52;
    tick;
    check("t5_first", 32'(out_data), 32'h51);
    check("t5_lane", 32'(out_lane), 32'h5);
    in_valid = '0;
    tick;
    check("t5_second", 32'(out_data), 32'h52);
    check("t5_cnt", 32'(drop_cnt), 32'd9);

    // CLR against a drop, then saturation
    ready = 1'b0;
    in_data[5] = 8'h60; in_valid = 8'h20;
    tick;
    check("t6_hold_out", 32'(out_data), 32'h52);
    clr = 1'b1; in_data[5] = 8'h61;
    tick;
    check("t6_clr_cnt", 32'(drop_cnt), 32'h0);
    check("t6_clr_sticky", 32'(sticky), 32'h0);
    clr = 1'b0;
    tick;
    check("t6_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t6_drop_sticky", 32'(sticky), 32'h20);
    clr = 1'b1; in_valid = '0;
    tick;
    clr = 1'b0;
    check("t6_clr2_sat", 32'(sat_drop_cnt), 32'h0);
    in_valid = 8'h20;
    repeat (20) tick;
    in_valid = '0;
    check("t6_cnt20", 32'(drop_cnt), 32'd20);
    check("t6_sat", 32'(sat_drop_cnt), 32'hF);
    check("t6_sticky", 32'(sticky), 32'h20);
    check("t6_out_still", 32'(out_data), 32'h52);

    // Async reset mid-stream
    ready = 1'b1; in_valid = 8'hFF;
    tick;
    check("t7_pre_valid", 32'(out_valid), 32'h1);
    check("t7_pre_data", 32'(out_data), 32'h60);
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("t7_async_valid", 32'(out_valid), 32'h0);
    check("t7_async_cnt", 32'(drop_cnt), 32'h0);
    #1 rst = 1'b0;
    in_data[0] = 8'hA0; in_data[3] = 8'hA3; in_data[7] = 8'hA7;
    in_valid = 8'h89;
    tick; in_valid = '0;
    tick;
    check("t7_first_lane", 32'(out_lane), 32'h0);
    check("t7_first_data", 32'(out_data), 32'hA0);
    tick;
    check("t7_second_lane", 32'(out_lane), 32'h3);
    tick;
    check("t7_third_lane", 32'(out_lane), 32'h7);
    check("t7_third_data", 32'(out_data), 32'hA7);

    // EN low: no captures, held samples still drain
    in_data[1] = 8'h11; in_data[2] = 8'h22; in_valid = 8'h06;
    tick;
    en = 1'b0;
    tick;
    check("t8_drain1", 32'(out_lane), 32'h1);
    check("t8_drain1_data", 32'(out_data), 32'h11);
    tick;
    check("t8_drain2", 32'(out_lane), 32'h2);
    tick;
    check("t8_no_capture", 32'(out_valid), 32'h0);
    in_valid = '0; en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
